mux_tree_pipe: RTL



---
 rtl/mux_pkg.sv | 23 ++
 rtl/mux_leaf.sv | 22 ++
 rtl/mux_tree_pipe.sv | 99 +++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the pipelined mux tree.
// Defaults describe the cache word/way selector configuration.
package mux_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_NUM_IN = 64;
  localparam int DEF_LEAF   = 16;
  localparam int DEF_GROUPS = DEF_NUM_IN / DEF_LEAF;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int num_groups(input int num_in, input int leaf);
    return num_in / leaf;
  endfunction

endpackage

// File: rtl/mux_leaf.sv
// Combinational LEAF:1 selector of WIDTH-bit words.
// An index with no matching word (non power-of-2 LEAF) yields zero.
import mux_pkg::*;

module mux_leaf #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEAF  = DEF_LEAF,
  localparam int SW   = clog2(LEAF)
) (
  input  logic [LEAF*WIDTH-1:0] data,
  input  logic [SW-1:0]         sel,
  output logic [WIDTH-1:0]      y
);

  always_comb begin
    y = '0;
    for (int i = 0; i < LEAF; i++) begin
      if (sel == SW'(i)) y = data[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/mux_tree_pipe.sv
// Two-stage pipelined NUM_IN:1 word selector with valid/ready on both sides.
// Stage 1 registers every leaf-group result; stage 2 picks the group.
import mux_pkg::*;

module mux_tree_pipe #(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int LEAF   = DEF_LEAF,
  localparam int SEL_W = clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int GROUPS = num_groups(NUM_IN, LEAF);
  localparam int LEAF_W = clog2(LEAF);
  localparam logic [SEL_W:0] NUM_IN_V = (SEL_W+1)'(NUM_IN);

  if ((NUM_IN % LEAF) != 0 || (NUM_IN / LEAF) > LEAF) begin : g_param_check
    $error("mux_tree_pipe: NUM_IN must be a multiple of LEAF and NUM_IN/LEAF <= LEAF");
  end

  logic [GROUPS*WIDTH-1:0] grp_y;
  logic [GROUPS*WIDTH-1:0] s1_data;
  logic [LEAF_W-1:0]       s1_grp;
  logic [SEL_W-1:0]        s1_sel;
  logic                    s1_err;
  logic                    s1_valid;
  logic [LEAF*WIDTH-1:0]   s2_in;
  logic [WIDTH-1:0]        s2_y;
  logic                    in_err;
  logic                    s1_adv;
  logic                    s2_adv;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign in_err   = {1'b0, in_sel} >= NUM_IN_V;

  for (genvar g = 0; g < GROUPS; g++) begin : g_leaf
    mux_leaf #(.WIDTH(WIDTH), .LEAF(LEAF)) u_leaf (
      .data (in_data[g*LEAF*WIDTH +: LEAF*WIDTH]),
      .sel  (in_sel[LEAF_W-1:0]),
      .y    (grp_y[g*WIDTH +: WIDTH])
    );
  end

  // Group slots beyond GROUPS only exist when NUM_IN < LEAF*LEAF; feed them zero.
  always_comb begin
    s2_in = '0;
    s2_in[GROUPS*WIDTH-1:0] = s1_data;
  end

  mux_leaf #(.WIDTH(WIDTH), .LEAF(LEAF)) u_root (
    .data (s2_in),
    .sel  (s1_grp),
    .y    (s2_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= grp_y;
        s1_grp  <= LEAF_W'(in_sel >> LEAF_W);
        s1_sel  <= in_sel;
        s1_err  <= in_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      out_err   <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= s1_err ? '0 : s2_y;
        out_sel  <= s1_sel;
        out_err  <= s1_err;
      end
    end
  end

endmodule
